// File: rtl/conv3x3_mac_pkg.sv
// ============================================================================
// Module   : conv3x3_mac_pkg
// Purpose  : Shared FSM encoding and result-width derivation for conv3x3_mac.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv3x3_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int c_KERN_TAPS = 9;
   localparam int c_BIAS_IDX  = 9;

   // Nine WIDTH x WIDTH products plus a bias need 2*WIDTH+4 bits of headroom.
   function automatic int acc_width(input int width);
      return 2 * width + 4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_row3.sv
// ============================================================================
// Module   : mac_row3
// Purpose  : One kernel row: three registered signed products, then their sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_row3 #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_en,
   input  logic [3*WIDTH-1:0]         i_pix,
   input  logic [3*WIDTH-1:0]         i_kern,
   output logic signed [2*WIDTH+1:0]  o_sum
);

   localparam int c_PW = 2 * WIDTH;
   localparam int c_SW = 2 * WIDTH + 2;

   logic signed [c_PW-1:0] w_prod [3];
   logic signed [c_PW-1:0] r_prod [3];
   logic signed [c_SW-1:0] w_sum;

   generate
      for (genvar c = 0; c < 3; c++) begin : g_tap
         logic signed [c_PW-1:0] w_a;
         logic signed [c_PW-1:0] w_b;
         assign w_a = {{WIDTH{i_pix[c*WIDTH+WIDTH-1]}},  i_pix[c*WIDTH +: WIDTH]};
         assign w_b = {{WIDTH{i_kern[c*WIDTH+WIDTH-1]}}, i_kern[c*WIDTH +: WIDTH]};
         assign w_prod[c] = w_a * w_b;
      end
   endgenerate

   assign w_sum = {{2{r_prod[0][c_PW-1]}}, r_prod[0]}
                + {{2{r_prod[1][c_PW-1]}}, r_prod[1]}
                + {{2{r_prod[2][c_PW-1]}}, r_prod[2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) r_prod[i] <= '0;
         o_sum <= '0;
      end else if (i_en) begin
         for (int i = 0; i < 3; i++) r_prod[i] <= w_prod[i];
         o_sum <= w_sum;
      end
   end

endmodule

`default_nettype wire

// File: rtl/conv3x3_mac.sv
// ============================================================================
// Module   : conv3x3_mac
// Purpose  : 3x3 signed convolution over three row FIFOs with bias and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv3x3_mac
   import conv3x3_mac_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int ADDR_BIT = 3,
   parameter int ACC_W    = acc_width(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_BIT:0]     img_w,
   input  logic [7:0]            n_rows,
   input  logic                  w_wen,
   input  logic [WIDTH-1:0]      w_in,
   input  logic [9*WIDTH-1:0]    win_in,
   input  logic                  win_avail,
   input  logic                  row_avail,
   output logic                  ren,
   output logic [ACC_W-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int c_SUM_W = 2 * WIDTH + 2;
   localparam int c_CW    = ADDR_BIT + 1;

   state_t                    r_state, w_state_nxt;
   logic [c_CW-1:0]           r_img_w, w_img_w_nxt;
   logic [c_CW-1:0]           r_col, w_col_nxt;
   logic [c_CW-1:0]           w_last_col;
   logic [7:0]                r_n_rows, w_n_rows_nxt;
   logic [7:0]                r_row, w_row_nxt;
   logic                      r_fcnt, w_fcnt_nxt;

   logic [3:0]                r_w_idx;
   logic [WIDTH-1:0]          r_k [c_KERN_TAPS];
   logic signed [ACC_W-1:0]   r_bias;

   logic                      r_v1, r_v2;
   logic                      w_pipe_en;
   logic                      w_issue;
   logic                      w_empty;
   logic [3*WIDTH-1:0]        w_krow [3];
   logic signed [c_SUM_W-1:0] w_rsum [3];
   logic signed [ACC_W-1:0]   w_rsum_ext [3];
   logic signed [ACC_W-1:0]   w_total;

   assign w_pipe_en  = !out_valid || out_ready;
   assign w_issue    = ren && (r_state == ST_RUN);
   assign w_empty    = !r_v1 && !r_v2 && !out_valid;
   assign w_last_col = r_img_w - c_CW'(3);
   assign busy       = (r_state != ST_IDLE);

   // Kernel/bias writes are only accepted while idle so a frame never sees a half-updated kernel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_idx <= '0;
         r_bias  <= '0;
         for (int i = 0; i < c_KERN_TAPS; i++) r_k[i] <= '0;
      end else if ((r_state == ST_IDLE) && w_wen) begin
         if (r_w_idx == 4'(c_BIAS_IDX)) begin
            r_bias  <= {{(ACC_W-WIDTH){w_in[WIDTH-1]}}, w_in};
            r_w_idx <= '0;
         end else begin
            r_k[r_w_idx] <= w_in;
            r_w_idx      <= r_w_idx + 4'd1;
         end
      end
   end

   generate
      for (genvar r = 0; r < 3; r++) begin : g_row
         assign w_krow[r] = {r_k[3*r+2], r_k[3*r+1], r_k[3*r]};

         mac_row3 #(
            .WIDTH (WIDTH)
         ) u_mac_row3 (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_pipe_en),
            .i_pix  (win_in[3*r*WIDTH +: 3*WIDTH]),
            .i_kern (w_krow[r]),
            .o_sum  (w_rsum[r])
         );

         assign w_rsum_ext[r] = {{(ACC_W-c_SUM_W){w_rsum[r][c_SUM_W-1]}}, w_rsum[r]};
      end
   endgenerate

   assign w_total = w_rsum_ext[0] + w_rsum_ext[1] + w_rsum_ext[2] + r_bias;

   // Stage valids travel alongside the data registers inside mac_row3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (w_pipe_en) begin
         r_v1      <= w_issue;
         r_v2      <= r_v1;
         out_valid <= r_v2;
         if (r_v2) out_data <= w_total;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_img_w  <= '0;
         r_n_rows <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_fcnt   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_img_w  <= w_img_w_nxt;
         r_n_rows <= w_n_rows_nxt;
         r_col    <= w_col_nxt;
         r_row    <= w_row_nxt;
         r_fcnt   <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_img_w_nxt  = r_img_w;
      w_n_rows_nxt = r_n_rows;
      w_col_nxt    = r_col;
      w_row_nxt    = r_row;
      w_fcnt_nxt   = r_fcnt;
      ren          = 1'b0;
      done         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_img_w_nxt  = img_w;
               w_n_rows_nxt = n_rows;
               w_col_nxt    = '0;
               w_row_nxt    = '0;
               w_fcnt_nxt   = 1'b0;
               w_state_nxt  = ST_RUN;
            end
         end
         ST_RUN: begin
            ren = win_avail && w_pipe_en;
            if (ren) begin
               if (r_col == w_last_col) begin
                  w_col_nxt   = '0;
                  w_fcnt_nxt  = 1'b0;
                  w_state_nxt = ST_FLUSH;
               end else begin
                  w_col_nxt = r_col + c_CW'(1);
               end
            end
         end
         ST_FLUSH: begin
            // The two trailing entries of each row are discarded regardless of backpressure.
            ren = row_avail;
            if (ren) begin
               if (r_fcnt) begin
                  w_fcnt_nxt = 1'b0;
                  if (r_row == r_n_rows - 8'd1) begin
                     w_state_nxt = ST_DRAIN;
                  end else begin
                     w_row_nxt   = r_row + 8'd1;
                     w_state_nxt = ST_RUN;
                  end
               end else begin
                  w_fcnt_nxt = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (w_empty) begin
               done        = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_mac.sv
// ============================================================================
// Module   : tb_conv3x3_mac
// Purpose  : Randomised scoreboard bench for conv3x3_mac with a FIFO/image model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv3x3_mac;

   localparam int WIDTH    = 8;
   localparam int ADDR_BIT = 3;
   localparam int ACC_W    = 2 * WIDTH + 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [ADDR_BIT:0]    img_w = '0;
   logic [7:0]           n_rows = '0;
   logic                 w_wen = 1'b0;
   logic [WIDTH-1:0]     w_in = '0;
   logic [9*WIDTH-1:0]   win_in = '0;
   logic                 win_avail = 1'b0;
   logic                 row_avail = 1'b0;
   logic                 ren;
   logic [ACC_W-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic                 busy;
   logic                 done;

   conv3x3_mac #(
      .WIDTH    (WIDTH),
      .ADDR_BIT (ADDR_BIT),
      .ACC_W    (ACC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .img_w     (img_w),
      .n_rows    (n_rows),
      .w_wen     (w_wen),
      .w_in      (w_in),
      .win_in    (win_in),
      .win_avail (win_avail),
      .row_avail (row_avail),
      .ren       (ren),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int kern [9];
   int bias;
   int img [0:15][0:7];
   int fq0[$], fq1[$], fq2[$];
   int exp_q[$];
   int n_out = 0;

   int avail_mode  = 0;   // 0 always, 1 alternate cycles, 2 random
   int ready_mode  = 0;   // 0 always ready, 1 random
   bit ready_force = 1'b0;

   function automatic int get_pix(input int r, input int c);
      case (r)
         0:       return (fq0.size() > c) ? fq0[c] : 0;
         1:       return (fq1.size() > c) ? fq1[c] : 0;
         default: return (fq2.size() > c) ? fq2[c] : 0;
      endcase
   endfunction

   // FIFO model: presents the front three entries of each row FIFO and pops on ren.
   initial begin : driver
      bit tog = 1'b0;
      bit gate;
      bit ren_s;
      int p;
      forever begin
         @(negedge clk);
         tog = ~tog;
         case (avail_mode)
            0:       gate = 1'b1;
            1:       gate = tog;
            default: gate = ($urandom_range(0, 2) != 0);
         endcase
         win_avail = gate && fq0.size() >= 3 && fq1.size() >= 3 && fq2.size() >= 3;
         row_avail = gate && fq0.size() >= 1 && fq1.size() >= 1 && fq2.size() >= 1;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               p = get_pix(r, c);
               win_in[(3*r+c)*WIDTH +: WIDTH] = p[WIDTH-1:0];
            end
         out_ready = ready_force ? 1'b0 : ((ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
         #4;
         ren_s = ren;
         if (ren_s) begin
            total++;
            if (!row_avail || !rst_n) begin
               bad++;
               $display("FAIL ren_gate: ren=1 with row_avail=%0b win_avail=%0b", row_avail, win_avail);
            end
         end
         @(posedge clk);
         if (ren_s && rst_n) begin
            if (fq0.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_empty: ren=1 but model FIFOs are empty, required ren=0");
            end else begin
               void'(fq0.pop_front());
               void'(fq1.pop_front());
               void'(fq2.pop_front());
            end
         end
      end
   end

   initial begin : monitor
      int e;
      int got;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && out_valid && out_ready) begin
            total++;
            got = int'($signed(out_data));
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL out_unexpected: got %0d, required no result", got);
            end else begin
               e = exp_q.pop_front();
               if (got != e) begin
                  bad++;
                  $display("FAIL out_data: got %0d, required %0d", got, e);
               end
            end
            n_out++;
         end
      end
   end

   task automatic set_kernel(input int mode);
      for (int i = 0; i < 9; i++)
         kern[i] = (mode == 0) ? 1 : (mode == 1) ? -128 : int'($urandom_range(0, 255)) - 128;
      bias = (mode == 0) ? 0 : (mode == 1) ? -128 : int'($urandom_range(0, 255)) - 128;
   endtask

   // Builds the image, fills the three FIFOs and queues every expected result of the frame.
   task automatic prep_frame(input int w, input int nr, input int pmode);
      int e;
      fq0.delete(); fq1.delete(); fq2.delete(); exp_q.delete();
      n_out = 0;
      for (int y = 0; y < nr + 2; y++)
         for (int x = 0; x < w; x++)
            img[y][x] = (pmode == 0) ? int'($urandom_range(0, 255)) - 128 : (pmode == 1) ? x + 1 : 127;
      for (int y = 0; y < nr; y++)
         for (int x = 0; x < w; x++) begin
            fq0.push_back(img[y][x]);
            fq1.push_back(img[y+1][x]);
            fq2.push_back(img[y+2][x]);
         end
      for (int y = 0; y < nr; y++)
         for (int x = 0; x <= w - 3; x++) begin
            e = bias;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  e += kern[3*r+c] * img[y+r][x+c];
            exp_q.push_back(e);
         end
   endtask

   task automatic write_weights(input bit with_start, input int w, input int nr);
      int t;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         t = (i < 9) ? kern[i] : bias;
         w_wen = 1'b1;
         w_in  = t[WIDTH-1:0];
         if (i == 9 && with_start) begin
            start  = 1'b1;
            img_w  = (ADDR_BIT+1)'(w);
            n_rows = 8'(nr);
         end
      end
      @(negedge clk);
      w_wen = 1'b0;
      start = 1'b0;
   endtask

   task automatic begin_frame(input int w, input int nr, input bit with_start);
      if (with_start) begin
         write_weights(1'b1, w, nr);
      end else begin
         @(negedge clk);
         img_w  = (ADDR_BIT+1)'(w);
         n_rows = 8'(nr);
         start  = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      #4;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_after_start: busy=%0b, required 1", busy);
      end
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #4;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout: done=0 after 3000 cycles, required 1");
      end else begin
         total++;
         if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL results_missing: %0d results outstanding at done, required 0", exp_q.size());
         end
         total++;
         if (fq0.size() != 0) begin
            bad++;
            $display("FAIL fifo_left: %0d entries unpopped at done, required 0", fq0.size());
         end
         @(negedge clk);
         #4;
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_done: busy=%0b done=%0b, required 0 0", busy, done);
         end
      end
   endtask

   task automatic check_count(input string name, input int got, input int req);
      total++;
      if (got != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit seen;
      bit quiet;
      logic [ACC_W-1:0] held;

      // reset values
      repeat (2) @(negedge clk);
      #4;
      check_count("rst_ren",       int'(ren),       0);
      check_count("rst_out_valid", int'(out_valid), 0);
      check_count("rst_out_data",  int'(out_data),  0);
      check_count("rst_busy",      int'(busy),      0);
      check_count("rst_done",      int'(done),      0);
      @(negedge clk);
      rst_n = 1'b1;

      // all-ones kernel over a ramp row: 18, 27, 36
      set_kernel(0);
      write_weights(1'b0, 0, 0);
      avail_mode = 0; ready_mode = 0;
      prep_frame(5, 1, 1);
      begin_frame(5, 1, 1'b0);
      wait_done();
      check_count("ramp_count", n_out, 3);

      // extreme negative kernel and bias with narrowest row
      set_kernel(1);
      write_weights(1'b0, 0, 0);
      prep_frame(3, 1, 2);
      begin_frame(3, 1, 1'b0);
      wait_done();
      check_count("extreme_count", n_out, 1);

      // five-cycle backpressure mid-row
      set_kernel(2);
      write_weights(1'b0, 0, 0);
      prep_frame(8, 2, 0);
      begin_frame(8, 2, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #4;
         if (out_valid) begin seen = 1'b1; break; end
      end
      ready_force = 1'b1;
      check_count("stall_setup", int'(seen), 1);
      @(negedge clk); #4;
      held = out_data;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(negedge clk); #4; end
         total++;
         if (ren !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
            bad++;
            $display("FAIL stall_hold: ren=%0b valid=%0b data=%0h, required 0 1 %0h", ren, out_valid, out_data, held);
         end
      end
      ready_force = 1'b0;
      wait_done();
      check_count("stall_count", n_out, 12);

      // win_avail toggling on alternate cycles
      avail_mode = 1;
      set_kernel(2);
      write_weights(1'b0, 0, 0);
      prep_frame(6, 1, 0);
      begin_frame(6, 1, 1'b0);
      wait_done();
      check_count("alt_count", n_out, 4);

      // bias written together with start, then w_wen/start pulses while busy
      avail_mode = 2; ready_mode = 1;
      set_kernel(2);
      prep_frame(7, 3, 0);
      begin_frame(7, 3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         w_wen = 1'b1; w_in = 8'h55; start = 1'b1; img_w = 4'd3; n_rows = 8'd1;
         @(negedge clk);
         w_wen = 1'b0; start = 1'b0;
      end
      wait_done();
      check_count("busy_ignore_count", n_out, 15);
      set_kernel(2);
      write_weights(1'b0, 0, 0);
      prep_frame(8, 2, 0);
      begin_frame(8, 2, 1'b0);
      wait_done();

      // randomized frames
      for (int f = 0; f < 4; f++) begin
         int w, nr;
         avail_mode = int'($urandom_range(0, 2));
         ready_mode = 1;
         w  = int'($urandom_range(3, 8));
         nr = int'($urandom_range(1, 4));
         set_kernel(2);
         write_weights(1'b0, 0, 0);
         prep_frame(w, nr, 0);
         begin_frame(w, nr, 1'b0);
         wait_done();
         check_count("rand_count", n_out, nr * (w - 2));
      end

      // asynchronous reset while a result is pending
      avail_mode = 0; ready_mode = 0;
      set_kernel(2);
      write_weights(1'b0, 0, 0);
      prep_frame(8, 3, 0);
      begin_frame(8, 3, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #2;
         if (out_valid) begin seen = 1'b1; break; end
      end
      check_count("reset_setup", int'(seen), 1);
      rst_n = 1'b0;
      #1;
      check_count("mid_rst_out_valid", int'(out_valid), 0);
      check_count("mid_rst_out_data",  int'(out_data),  0);
      check_count("mid_rst_ren",       int'(ren),       0);
      check_count("mid_rst_busy",      int'(busy),      0);
      fq0.delete(); fq1.delete(); fq2.delete(); exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #4;
         if (done || busy) quiet = 1'b0;
      end
      check_count("no_done_after_reset", int'(quiet), 1);

      // recovery after reset
      set_kernel(0);
      write_weights(1'b0, 0, 0);
      prep_frame(5, 1, 1);
      begin_frame(5, 1, 1'b0);
      wait_done();
      check_count("recover_count", n_out, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/conv3x3_mac.md
# conv3x3_mac

Pipelined 3×3 convolution engine that sits directly downstream of the three row line-buffer FIFOs. Each row FIFO exposes its three front entries, giving a 3×3 window. The block pops the three FIFOs in lockstep, multiplies each window by a locally stored 3×3 signed kernel, adds a bias, and emits one full-precision result per window with a valid/ready handshake. At the end of each image row it discards the two trailing row entries, and it signals `done` after a programmed number of output rows.

## Interface
- `WIDTH`, 8: pixel and weight width, signed two's complement.
- `ADDR_BIT`, 3: FIFO address width; the maximum row length is 2**ADDR_BIT.
- `ACC_W`, 2*WIDTH+4: result width; must be at least 2*WIDTH+4.

Ports:
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Reset; asynchronous, active-low.
- `start`  in  1  Starts a frame; sampled only in IDLE.
- `img_w`  in  ADDR_BIT+1  Row length; legal range 3..2**ADDR_BIT; sampled at start.
- `n_rows`  in  8  Output rows per frame; legal range ≥1; sampled at start.
- `w_wen`  in  1  Writes one kernel/bias word; honoured only in IDLE.
- `w_in`  in  WIDTH  Kernel or bias word.
- `win_in`  in  9*WIDTH  Window; element (r,c) sits at bits [(3r+c)*WIDTH +: WIDTH]; r=0 is the oldest row, c=0 the leftmost column.
- `win_avail`  in  1  All three FIFOs hold at least 3 entries.
- `row_avail`  in  1  All three FIFOs are non-empty.
- `ren`  out  1  Common pop strobe to the three FIFOs; combinational.
- `out_data`  out  ACC_W  Signed result.
- `out_valid`  out  1  Result valid.
- `out_ready`  in  1  Downstream accepts the result.
- `busy`  out  1  High whenever state ≠ IDLE.
- `done`  out  1  One-cycle pulse at frame end.

## Operation
Weight load:
- `w_idx` counts 0..9.
- Words 0..8 go to k[r][c] in the same order as the window packing.
- Word 9 is the bias, sign-extended to ACC_W.
- `w_idx` wraps from 9 to 0.
- `w_wen` outside IDLE is ignored and does not move `w_idx`.

FSM states:
- IDLE: on `start`, latch `img_w` and `n_rows`, clear `col` and `row`, and go to RUN.
- RUN: a window is issued when `ren` = `win_avail` & `pipe_en`. Each issued window increments `col`. The issue with `col` = img_w-3 clears `col` and moves to FLUSH.
- FLUSH: `ren` = `row_avail`, independent of `pipe_en`; no data enters the pipeline. After 2 pops:
  - if `row` = n_rows-1, go to DRAIN;
  - otherwise increment `row` and return to RUN.
- DRAIN: `ren` = 0. When all stage valids and `out_valid` are 0, pulse `done` and go to IDLE.

Pipeline, with `pipe_en` = !out_valid | out_ready:
- S1: nine signed WIDTH×WIDTH products, registered.
- S2: three row sums, registered.
- S3: row sums + bias, written to `out_data`/`out_valid`.

Pipeline rules:
- Every stage advances only while `pipe_en` is high.
- `out_valid` stays high and `out_data` holds stable until `out_ready` is sampled high.

Arithmetic:
- Full precision, no saturation or rounding.
- ACC_W = 2*WIDTH+4 covers 9 products plus bias without overflow.

## Timing
- Reset values: `ren`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0; all stage valids 0; kernel and bias 0; `w_idx`=0; state IDLE.
- Reset taking effect mid-frame aborts immediately; no `done` is generated.
- `win_in` must be valid in the same cycle `ren` is high; it is captured at that edge, the same edge at which the FIFOs pop.
- Latency: a window issued in cycle t gives `out_valid`=1 in cycle t+3 when there is no stall.
- Throughput: 1 window per cycle in RUN.
- A row costs img_w-2 issue cycles plus 2 flush cycles.
- Backpressure: `out_ready`=0 while `out_valid`=1 freezes S1–S3 and forces `ren`=0 in RUN.
- `start` outside IDLE is ignored.
- `start` together with `w_wen` in IDLE: the write is performed and the frame starts.
- img_w=3: one window per row, then FLUSH.
- `done` is asserted in the cycle the FSM leaves DRAIN; `busy` falls in the next cycle.

## Structure
- Shared package holds the FSM state encoding (IDLE, RUN, FLUSH, DRAIN) and the ACC_W derivation.
- One sub-module: `mac_row3`, which computes 3 products and one row sum. It is instantiated 3× and covers S1–S2.

## Test plan
- Load the kernel as all 1s with bias 0. Drive img_w=5, n_rows=1, pixels 1..5 in every row. Expect outputs 18, 27, 36; then 2 flush pops; then `done`.
- Load the kernel as all -128 with bias -128. Use a window of all 127. Expect out_data = 9·(-16256) - 128 = -146432 with no wrap.
- With a stream running, hold `out_ready`=0 for 5 cycles. Expect `ren`=0 and `out_data` stable during the stall, then no lost or duplicated results.
- Toggle `win_avail` on alternate cycles. Expect issues only in available cycles and the result count equal to img_w-2.
- Assert `rst_n` low mid-row with `out_valid`=1. Expect all outputs 0 immediately, state IDLE, and no `done`.
- Pulse `w_wen` and `start` while `busy`. Expect both ignored and `w_idx` unchanged.
